// File: rtl/stream_demux2.sv
// stream_demux2: registered 1-to-2 stream demultiplexer.
// One valid/ready input stream is steered beat by beat to port 0 or port 1
// according to in_sel. Each port owns a one-entry output register, a
// two-state EMPTY/FULL FSM and a wrapping delivered-beat counter.
// Optional simulation feature: define SEL_XCHECK_EN to drop beats whose
// in_sel is X/Z and raise the sticky sel_err flag. Without it, an unresolved
// select falls through to port 0 and sel_err is tied low.
module stream_demux2 #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             sel_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  state_t           state0_r, state1_r;
  state_t           state0_nxt_s, state1_nxt_s;
  logic [WIDTH-1:0] data0_r, data1_r;
  logic [CNT_W-1:0] cnt0_r, cnt1_r;
  logic             sel_err_r;
  logic             dst_s;
  logic             drop_s;
  logic             in_ready_s;
  logic             load0_s, load1_s;
  logic             drain0_s, drain1_s;

  // Resolve the destination port; an unresolved select either drops the beat or falls to port 0.
  always_comb begin
    dst_s  = 1'b0;
    drop_s = 1'b0;
`ifdef SEL_XCHECK_EN
    if (in_valid && $isunknown(in_sel)) begin
      drop_s = 1'b1;
      dst_s  = 1'b0;
    end else if (in_sel == 1'b1) begin
      dst_s = 1'b1;
    end else begin
      dst_s = 1'b0;
    end
`else
    if (in_sel == 1'b1) begin
      dst_s = 1'b1;
    end else begin
      dst_s = 1'b0;
    end
`endif
  end

  // Input ready depends only on the selected port, so a stalled port never blocks the other.
  always_comb begin
    in_ready_s = 1'b0;
    if (!rst_n) begin
      in_ready_s = 1'b0;
    end else if (drop_s) begin
      in_ready_s = 1'b1;
    end else if (dst_s) begin
      in_ready_s = (state1_r == EMPTY) || out1_ready;
    end else begin
      in_ready_s = (state0_r == EMPTY) || out0_ready;
    end
  end

  assign load0_s  = in_valid && in_ready_s && !drop_s && !dst_s;
  assign load1_s  = in_valid && in_ready_s && !drop_s &&  dst_s;
  assign drain0_s = (state0_r == FULL) && out0_ready;
  assign drain1_s = (state1_r == FULL) && out1_ready;

  // Next-state logic for both port FSMs; a load always wins, so drain+load stays FULL.
  always_comb begin
    state0_nxt_s = state0_r;
    state1_nxt_s = state1_r;
    case (state0_r)
      EMPTY: begin
        if (load0_s) state0_nxt_s = FULL;
        else         state0_nxt_s = EMPTY;
      end
      FULL: begin
        if (load0_s)       state0_nxt_s = FULL;
        else if (drain0_s) state0_nxt_s = EMPTY;
        else               state0_nxt_s = FULL;
      end
      default: state0_nxt_s = EMPTY;
    endcase
    case (state1_r)
      EMPTY: begin
        if (load1_s) state1_nxt_s = FULL;
        else         state1_nxt_s = EMPTY;
      end
      FULL: begin
        if (load1_s)       state1_nxt_s = FULL;
        else if (drain1_s) state1_nxt_s = EMPTY;
        else               state1_nxt_s = FULL;
      end
      default: state1_nxt_s = EMPTY;
    endcase
  end

  // Port state registers; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state0_r <= EMPTY;
      state1_r <= EMPTY;
    end else begin
      state0_r <= state0_nxt_s;
      state1_r <= state1_nxt_s;
    end
  end

  // Output data registers only change on a load, so data holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data0_r <= DATA_ZERO;
      data1_r <= DATA_ZERO;
    end else begin
      if (load0_s) data0_r <= in_data;
      if (load1_s) data1_r <= in_data;
    end
  end

  // Delivered-beat counters, wrapping silently at the top of their range.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_r <= CNT_ZERO;
      cnt1_r <= CNT_ZERO;
    end else begin
      if (drain0_s) cnt0_r <= cnt0_r + CNT_ONE;
      if (drain1_s) cnt1_r <= cnt1_r + CNT_ONE;
    end
  end

  // Sticky select-error flag, set when a beat with an unresolved select is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else begin
`ifdef SEL_XCHECK_EN
      if (drop_s) begin
        sel_err_r <= 1'b1;
        $error("stream_demux2: unresolved in_sel with in_valid at time %0t", $time);
      end
`else
      sel_err_r <= 1'b0;
`endif
    end
  end

  assign in_ready   = in_ready_s;
  assign out0_valid = (state0_r == FULL);
  assign out1_valid = (state1_r == FULL);
  assign out0_data  = data0_r;
  assign out1_data  = data1_r;
  assign cnt0       = cnt0_r;
  assign cnt1       = cnt1_r;
  assign sel_err    = sel_err_r;

endmodule
